// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: sequential instruction prefetcher feeding the IF/ID stage.
// Issues word fetches over a valid/ready request channel and buffers in-order
// responses with their PCs in a DEPTH-entry FIFO. A redirect flushes the FIFO
// and drops stale in-flight responses before fetching resumes at the target.
//
// Handshakes: a transfer happens on a channel in any cycle where valid and
// ready are both high. valid never depends on ready of the same channel.
// imem_resp_valid has no ready; each accepted request yields exactly one
// in-order response.
//
// Optional feature macro: PREFETCH_BYPASS_EN. When it is defined, a response
// that arrives while the FIFO is empty (FETCH state, no redirect) is presented
// to decode in the same cycle. If decode takes it, the entry is not written.
module instr_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   typedef enum logic {FETCH = 1'b0, FLUSH = 1'b1} state_t;

   state_t        state;
   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] occupancy;
   logic [CW-1:0] drop_cnt;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [31:0]   fifo_instr [DEPTH];
   logic [31:0]   fifo_pc    [DEPTH];

   logic          resp_fire;
   logic          req_fire;
   logic          head_out;
   logic          byp_valid;
   logic          byp_take;
   logic          pop;
   logic          push;
   logic          resp_accept;
   logic [CW:0]   credit_sum;
   logic [CW-1:0] req_inc;
   logic [CW-1:0] resp_dec;
   logic [CW-1:0] drop_after;
   logic [CW-1:0] flush_dec;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign resp_fire  = imem_resp_valid && (outstanding != '0);
   assign credit_sum = {1'b0, occupancy} + {1'b0, outstanding};
   assign req_inc    = CW'(req_fire);
   assign resp_dec   = CW'(resp_fire);
   assign drop_after = outstanding - resp_dec;
   assign flush_dec  = CW'(resp_fire && (drop_cnt != '0));

   // Credit rule: buffered plus in-flight never exceeds DEPTH, so pushes never overflow.
   assign imem_req_valid = !reset && (state == FETCH) && !redirect_valid && (credit_sum < DEPTH_C);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign head_out = (occupancy != '0) && !redirect_valid;

`ifdef PREFETCH_BYPASS_EN
   assign byp_valid = (occupancy == '0) && (state == FETCH) && !redirect_valid && resp_fire;
`else
   assign byp_valid = 1'b0;
`endif

   assign byp_take    = byp_valid && out_ready;
   assign pop         = head_out && out_ready;
   assign resp_accept = (state == FETCH) && !redirect_valid && resp_fire;
   assign push        = resp_accept && !byp_take;

   assign out_valid = head_out || byp_valid;
   assign out_instr = byp_valid ? imem_resp_data : (head_out ? fifo_instr[rd_ptr] : 32'h0);
   assign out_pc    = byp_valid ? resp_pc        : (head_out ? fifo_pc[rd_ptr]    : 32'h0);

   // Control state: fetch/flush FSM, PCs, credit counters and FIFO pointers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= FETCH;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         occupancy   <= '0;
         drop_cnt    <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else if (redirect_valid) begin
         // Same-cycle response is already stale, so it does not count toward drop_cnt.
         fetch_pc    <= redirect_pc;
         resp_pc     <= redirect_pc;
         outstanding <= drop_after;
         drop_cnt    <= drop_after;
         occupancy   <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         state       <= (drop_after != '0) ? FLUSH : FETCH;
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         outstanding <= outstanding + req_inc - resp_dec;
         if (resp_accept) begin
            resp_pc <= resp_pc + 32'd4;
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         occupancy <= occupancy + CW'(push) - CW'(pop);
         if (state == FLUSH) begin
            drop_cnt <= drop_cnt - flush_dec;
            if ((drop_cnt - flush_dec) == '0) begin
               state <= FETCH;
            end
         end
      end
   end

   // FIFO storage: data only, validity is tracked by occupancy and pointers.
   always_ff @(posedge clk) begin
      if (push && !redirect_valid) begin
         fifo_instr[wr_ptr] <= imem_resp_data;
         fifo_pc[wr_ptr]    <= resp_pc;
      end
   end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue (DEPTH=4, RESET_PC=0x100).
// A small in-order memory responder with programmable latency answers fetches;
// instruction words are addr ^ 0x113 so the word at 0x100 is 0x00000013.
module tb_instr_prefetch_queue;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

`ifdef PREFETCH_BYPASS_EN
   localparam int BYP = 1;
`else
   localparam int BYP = 0;
`endif
   // Cycles from request acceptance to the entry appearing on out_*.
   localparam int FO = (BYP != 0) ? 1 : 2;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          lat = 1;
   logic [31:0] pend_addr [$];
   int          pend_due  [$];

   instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0100)) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instr       (out_instr),
      .out_pc          (out_pc)
   );

   // Clock
   always #5 clk = ~clk;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return a ^ 32'h0000_0113;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Called at the negedge: record an accepted request, advance one cycle,
   // then drive the memory response due in the new cycle.
   task automatic adv();
      if (imem_req_valid && imem_req_ready) begin
         pend_addr.push_back(imem_req_addr);
         pend_due.push_back(cyc + lat);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = memfn(pend_addr[0]);
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'h0;
      end
   endtask

   task automatic do_reset();
      reset           = 1'b1;
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      redirect_valid  = 1'b0;
      redirect_pc     = 32'h0;
      out_ready       = 1'b1;
      lat             = 1;
      pend_addr.delete();
      pend_due.delete();
      @(negedge clk);
      check("rst_req_valid", 32'(imem_req_valid), 32'h0);
      check("rst_req_addr",  imem_req_addr, 32'h0000_0100);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_instr", out_instr, 32'h0);
      check("rst_out_pc",    out_pc, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 0;
   endtask

   initial begin
      logic [31:0] e;
      int          acc;

      // ---- 1: streaming, 1-cycle memory, decode always ready ----
      do_reset();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("t1_req_valid", 32'(imem_req_valid), 32'h1);
         check("t1_req_addr", imem_req_addr, 32'h100 + 32'(4 * c));
         check("t1_out_valid", 32'(out_valid), 32'(c >= FO));
         if (c >= FO) begin
            e = 32'h100 + 32'(4 * (c - FO));
            check("t1_out_pc", out_pc, e);
            check("t1_out_instr", out_instr, memfn(e));
         end
         adv();
      end

      // ---- 2: decode stalled fills exactly DEPTH, then drains in order ----
      do_reset();
      out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready) acc++;
         adv();
      end
      check("t2_accepted", 32'(acc), 32'd4);
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) check("t2_full_req_valid", 32'(imem_req_valid), 32'h0);
         if (k == 1) begin
            check("t2_resume_req_valid", 32'(imem_req_valid), 32'h1);
            check("t2_resume_req_addr", imem_req_addr, 32'h110);
         end
         e = 32'h100 + 32'(4 * k);
         check("t2_out_valid", 32'(out_valid), 32'h1);
         check("t2_out_pc", out_pc, e);
         check("t2_out_instr", out_instr, memfn(e));
         adv();
      end

      // ---- 3: redirect with 2 outstanding, 3-cycle memory ----
      do_reset();
      lat = 3;
      @(negedge clk); adv();
      @(negedge clk); adv();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      @(negedge clk);
      check("t3_redir_req_valid", 32'(imem_req_valid), 32'h0);
      check("t3_redir_out_valid", 32'(out_valid), 32'h0);
      adv();
      redirect_valid = 1'b0;
      for (int c = 3; c < 5; c++) begin
         @(negedge clk);
         check("t3_flush_req_valid", 32'(imem_req_valid), 32'h0);
         check("t3_flush_out_valid", 32'(out_valid), 32'h0);
         adv();
      end
      @(negedge clk);
      check("t3_resume_req_valid", 32'(imem_req_valid), 32'h1);
      check("t3_resume_req_addr", imem_req_addr, 32'h200);
      check("t3_c5_out_valid", 32'(out_valid), 32'h0);
      adv();
      for (int c = 6; c < 8; c++) begin
         @(negedge clk);
         check("t3_wait_out_valid", 32'(out_valid), 32'h0);
         adv();
      end
      @(negedge clk);
      check("t3_c8_out_valid", 32'(out_valid), 32'(BYP));
      check("t3_c8_out_pc", out_pc, (BYP != 0) ? 32'h200 : 32'h0);
      adv();
      @(negedge clk);
      e = (BYP != 0) ? 32'h204 : 32'h200;
      check("t3_c9_out_valid", 32'(out_valid), 32'h1);
      check("t3_c9_out_pc", out_pc, e);
      check("t3_c9_out_instr", out_instr, memfn(e));
      adv();

      // ---- 4: redirect coincides with the only outstanding response ----
      do_reset();
      @(negedge clk); adv();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      @(negedge clk);
      check("t4_resp_present", 32'(imem_resp_valid), 32'h1);
      check("t4_redir_req_valid", 32'(imem_req_valid), 32'h0);
      check("t4_redir_out_valid", 32'(out_valid), 32'h0);
      adv();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      @(negedge clk);
      check("t4_next_req_valid", 32'(imem_req_valid), 32'h1);
      check("t4_next_req_addr", imem_req_addr, 32'h200);
      check("t4_dropped_out_valid", 32'(out_valid), 32'h0);
      adv();
      @(negedge clk);
      check("t4_c3_out_valid", 32'(out_valid), 32'(BYP));
      check("t4_c3_out_pc", out_pc, (BYP != 0) ? 32'h200 : 32'h0);
      adv();
      @(negedge clk);
      check("t4_c4_out_pc", out_pc, (BYP != 0) ? 32'h204 : 32'h200);
      adv();

      // ---- 5: fetch address wraps past 0xFFFF_FFFC ----
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      @(negedge clk);
      check("t5_redir_req_valid", 32'(imem_req_valid), 32'h0);
      adv();
      redirect_valid = 1'b0;
      for (int c = 1; c < 7; c++) begin
         @(negedge clk);
         if (c < 5) check("t5_req_addr", imem_req_addr, 32'hFFFF_FFF8 + 32'(4 * (c - 1)));
         if (c >= 1 + FO) begin
            e = 32'hFFFF_FFF8 + 32'(4 * (c - 1 - FO));
            check("t5_out_pc", out_pc, e);
            check("t5_out_instr", out_instr, memfn(e));
         end
         adv();
      end

      // ---- 6: first response latency to decode (bypass-dependent) ----
      do_reset();
      @(negedge clk); adv();
      @(negedge clk);
      check("t6_c1_out_valid", 32'(out_valid), 32'(BYP));
      check("t6_c1_out_instr", out_instr, (BYP != 0) ? 32'h0000_0013 : 32'h0);
      check("t6_c1_out_pc", out_pc, (BYP != 0) ? 32'h100 : 32'h0);
      adv();
      @(negedge clk);
      e = (BYP != 0) ? 32'h104 : 32'h100;
      check("t6_c2_out_valid", 32'(out_valid), 32'h1);
      check("t6_c2_out_pc", out_pc, e);
      check("t6_c2_out_instr", out_instr, memfn(e));
      adv();

      // ---- 7: spurious response with nothing outstanding is ignored ----
      do_reset();
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      check("t7_c0_out_valid", 32'(out_valid), 32'h0);
      adv();
      imem_req_ready = 1'b1;
      @(negedge clk);
      check("t7_c1_out_valid", 32'(out_valid), 32'h0);
      check("t7_c1_req_valid", 32'(imem_req_valid), 32'h1);
      check("t7_c1_req_addr", imem_req_addr, 32'h100);
      adv();
      @(negedge clk); adv();
      @(negedge clk);
      check("t7_c3_out_pc", out_pc, (BYP != 0) ? 32'h104 : 32'h100);
      adv();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
